// File: rtl/seq_circuit_pkg.sv
// rtl/seq_circuit_pkg.sv - shared constants, state encodings and next-state/output helpers
//
// Holds the state register width, the four state encodings and two pure
// functions describing the machine. The functions are the single source of
// the next-state and Mealy output equations, so the RTL and any checker that
// wants a cycle-level reference use the same definition.
package seq_circuit_pkg;

    localparam int SEQ_STATE_W = 2;

    // Encoding is {A,B}: A is bit 1, B is bit 0.
    typedef enum logic [SEQ_STATE_W-1:0] {
        S0 = 2'b00,  // idle
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } seq_state_t;

    // A+ = (A & x) | (B & x)
    // B+ = ~A & x
    function automatic logic [SEQ_STATE_W-1:0] seq_next_state(
        input logic [SEQ_STATE_W-1:0] cur,
        input logic                   x
    );
        logic a;
        logic b;
        a = cur[1];
        b = cur[0];
        return {(a & x) | (b & x), ~a & x};
    endfunction

    // y = (A | B) & ~x : a run of 1s just ended while the machine was busy.
    function automatic logic seq_output(
        input logic [SEQ_STATE_W-1:0] cur,
        input logic                   x
    );
        return (cur[1] | cur[0]) & ~x;
    endfunction

endpackage

// File: rtl/seq_circuit.sv
// rtl/seq_circuit.sv - two-flip-flop Mealy detector flagging the end of a run of 1s
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset; forces state to 00 immediately
//   x      in   serial input, sampled at rising clk
//   state  out  [1:0] current state register {A,B}
//   y      out  Mealy output, combinational from state and x
//
// A sustained x=1 walks S0 -> S1 -> S3 -> S2 and then holds in S2. Any x=0
// sends the machine back to S0 on the next edge, and y is high in the cycle
// where x=0 is presented to a non-idle state. y is not registered, so it can
// glitch with x mid-cycle; consumers sample it at the clock edge.
module seq_circuit
    import seq_circuit_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   x,
    output logic [SEQ_STATE_W-1:0] state,
    output logic                   y
);

    logic [SEQ_STATE_W-1:0] state_q;
    logic [SEQ_STATE_W-1:0] state_d;

    // All four encodings are reachable, so no recovery path is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = seq_next_state(state_q, x);
        y       = seq_output(state_q, x);
    end

    assign state = state_q;

endmodule

// File: tb/tb_seq_circuit.sv
// tb/tb_seq_circuit.sv - self-checking bench for seq_circuit
module tb_seq_circuit;

    logic       clk;
    logic       reset;
    logic       x;
    logic [1:0] state;
    logic       y;

    int total;
    int bad;

    // Reference: length of the current run of sampled 1s (0 = idle).
    int run_len;
    bit cmp_en;

    seq_circuit dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .state (state),
        .y     (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: state is a function of how many consecutive 1s have
    // been sampled since the last 0 or reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) run_len = 0;
        else if (x === 1'b1) run_len = run_len + 1;
        else run_len = 0;
    end

    function automatic logic [1:0] model_state(input int n);
        if (n == 0) return 2'b00;
        else if (n == 1) return 2'b01;
        else if (n == 2) return 2'b11;
        else return 2'b10;
    endfunction

    function automatic logic model_y(input int n, input logic xi);
        return (n != 0) && (xi == 1'b0);
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model-vs-DUT compare on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_state", state, model_state(run_len));
            chk("cmp_y", {1'b0, y}, {1'b0, model_y(run_len, x)});
        end
    end

    // Advance one rising edge and stop just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        run_len = 0;
        cmp_en  = 1'b0;
        reset   = 1'b0;
        x       = 1'b0;

        // Reset hold
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_state", state, 2'b00);
        chk("rst_y", {1'b0, y}, 2'b00);

        // Idle hold
        reset = 1'b1;
        tick();
        tick();
        chk("idle_state", state, 2'b00);
        chk("idle_y", {1'b0, y}, 2'b00);

        // One-run walk: 01, 11, 10, 10
        x = 1'b1;
        tick(); chk("walk1", state, 2'b01); chk("walk1_y", {1'b0, y}, 2'b00);
        tick(); chk("walk2", state, 2'b11); chk("walk2_y", {1'b0, y}, 2'b00);
        tick(); chk("walk3", state, 2'b10); chk("walk3_y", {1'b0, y}, 2'b00);
        tick(); chk("walk4", state, 2'b10); chk("walk4_y", {1'b0, y}, 2'b00);

        // End-of-run detect from S2: y rises in the same cycle
        x = 1'b0;
        #1;
        chk("s2_end_y", {1'b0, y}, 2'b01);
        tick();
        chk("s2_end_state", state, 2'b00);
        chk("s2_end_y0", {1'b0, y}, 2'b00);

        // Short pulse from S0 via S1
        x = 1'b1;
        tick();
        chk("pulse_s1", state, 2'b01);
        x = 1'b0;
        #1;
        chk("pulse_s1_y", {1'b0, y}, 2'b01);
        tick();
        chk("pulse_s1_back", state, 2'b00);

        // End of run from S3
        x = 1'b1;
        tick();
        tick();
        chk("pulse_s3", state, 2'b11);
        x = 1'b0;
        #1;
        chk("pulse_s3_y", {1'b0, y}, 2'b01);
        tick();
        chk("pulse_s3_back", state, 2'b00);

        // Reset mid-run in S3 with x=1, well away from any edge
        x = 1'b1;
        tick();
        tick();
        chk("mid_pre", state, 2'b11);
        reset = 1'b0;
        #1;
        chk("mid_rst_state", state, 2'b00);
        chk("mid_rst_y", {1'b0, y}, 2'b00);
        #1;
        reset = 1'b1;
        tick();
        chk("mid_release", state, 2'b01);

        // Reset held low across a rising edge with x=1: state stays 00
        reset = 1'b0;
        tick();
        chk("rst_edge_state", state, 2'b00);
        reset = 1'b1;
        tick();
        chk("rst_edge_release", state, 2'b01);

        // Pseudo-random tail exercised through the model compare only
        for (int i = 0; i < 40; i++) begin
            x = 1'($urandom_range(0, 1));
            tick();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
